// File: rtl/packet_loader.sv
// packet_loader: 1-bit serial frames -> four DEPTH-slot FIFO images; define PARITY_CHECK_EN for a trailing parity bit.
// Latency 0 (stored on the D0/P sampling edge); no backpressure: frames aimed at a full buffer are dropped and counted.
module packet_loader #(
   parameter int DEPTH  = 6,
   parameter int DATA_W = 2,
   parameter int CNT_W  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        bit_in,
   input  logic [3:0]                  pop,
   output logic [DEPTH*(DATA_W+1)-1:0] buffer1_o,
   output logic [DEPTH*(DATA_W+1)-1:0] buffer2_o,
   output logic [DEPTH*(DATA_W+1)-1:0] buffer3_o,
   output logic [DEPTH*(DATA_W+1)-1:0] buffer4_o,
   output logic [3:0]                  full,
   output logic [3:0]                  empty,
   output logic                        wr_stb,
`ifdef PARITY_CHECK_EN
   output logic [CNT_W-1:0]            par_err_cnt,
`endif
   output logic [CNT_W-1:0]            drop_cnt
);

   localparam int SW = DATA_W + 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [2:0] {IDLE, ID1, ID0, D1, D0, PAR} state_t;

   state_t        state;
   logic [1:0]    id_q;
   logic          d1_q;
`ifdef PARITY_CHECK_EN
   logic          d0_q;
`endif

   logic [SW-1:0] slot     [4][DEPTH];
   logic [SW-1:0] nxt_slot [4][DEPTH];
   logic [CW-1:0] cnt      [4];
   logic [CW-1:0] nxt_cnt  [4];
   logic          frame_done;
   logic          frame_ok;
   logic          any_wr;
   logic          any_drop;
   logic [SW-1:0] new_slot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         id_q  <= '0;
         d1_q  <= 1'b0;
`ifdef PARITY_CHECK_EN
         d0_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (bit_in) state <= ID1;
            ID1: begin
               id_q[1] <= bit_in;
               state   <= ID0;
            end
            ID0: begin
               id_q[0] <= bit_in;
               state   <= D1;
            end
            D1: begin
               d1_q  <= bit_in;
               state <= D0;
            end
`ifdef PARITY_CHECK_EN
            D0: begin
               d0_q  <= bit_in;
               state <= PAR;
            end
            PAR:     state <= IDLE;
`else
            D0:      state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PARITY_CHECK_EN
   assign frame_done = (state == PAR);
   assign frame_ok   = ~^{id_q, d1_q, d0_q, bit_in};
   assign new_slot   = {d1_q, d0_q, 1'b1};
`else
   assign frame_done = (state == D0);
   assign frame_ok   = 1'b1;
   assign new_slot   = {d1_q, bit_in, 1'b1};
`endif

   // Pop is applied before the write, so a full buffer popped on the write edge still accepts it.
   always_comb begin
      nxt_slot = slot;
      nxt_cnt  = cnt;
      any_wr   = 1'b0;
      any_drop = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (pop[k] && (cnt[k] != '0)) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               nxt_slot[k][i] = slot[k][i+1];
            end
            nxt_slot[k][DEPTH-1] = '0;
            nxt_cnt[k] = cnt[k] - 1'b1;
         end
         if (frame_done && frame_ok && (id_q == 2'(k))) begin
            if (nxt_cnt[k] != DEPTH_C) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (CW'(i) == nxt_cnt[k]) nxt_slot[k][i] = new_slot;
               end
               nxt_cnt[k] = nxt_cnt[k] + 1'b1;
               any_wr     = 1'b1;
            end else begin
               any_drop = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
               slot[k][i] <= '0;
            end
            cnt[k] <= '0;
         end
         full     <= '0;
         empty    <= '1;
         wr_stb   <= 1'b0;
         drop_cnt <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
               slot[k][i] <= nxt_slot[k][i];
            end
            cnt[k]   <= nxt_cnt[k];
            full[k]  <= (nxt_cnt[k] == DEPTH_C);
            empty[k] <= (nxt_cnt[k] == '0);
         end
         wr_stb <= any_wr;
         if (any_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      end
   end

`ifdef PARITY_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_err_cnt <= '0;
      end else if (frame_done && !frame_ok && (par_err_cnt != '1)) begin
         par_err_cnt <= par_err_cnt + 1'b1;
      end
   end
`endif

   for (genvar i = 0; i < DEPTH; i++) begin : g_out
      assign buffer1_o[SW*i +: SW] = slot[0][i];
      assign buffer2_o[SW*i +: SW] = slot[1][i];
      assign buffer3_o[SW*i +: SW] = slot[2][i];
      assign buffer4_o[SW*i +: SW] = slot[3][i];
   end

endmodule
